// File: rtl/tx_fmt_queue.sv
// tx_fmt_queue: transmit-side stage between the Lab2 adder/echo logic and the UART.
// Raw echo bytes and 8-bit results (expanded to two uppercase hex digits plus CR/LF)
// are merged into a small circular FIFO. The FIFO is drained one character at a time
// with a fixed strobe/gap/wait handshake against bu_tx_busy.
// Optional build macro: TXQ_PREFIX_EN adds a leading '=' to each expanded result.
module tx_fmt_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       Gl_rst,
    input  logic [7:0] echo_data,
    input  logic       echo_valid,
    input  logic [7:0] res_data,
    input  logic       res_valid,
    input  logic       bu_tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_data_rdy,
    output logic       fmt_busy,
    output logic       q_full,
    output logic       q_empty,
    output logic       q_ovf
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

`ifdef TXQ_PREFIX_EN
    typedef enum logic [2:0] {
        F_IDLE,
        F_EQ,
        F_HI,
        F_LO,
        F_CR,
        F_LF
    } fmt_state_t;
`else
    typedef enum logic [2:0] {
        F_IDLE,
        F_HI,
        F_LO,
        F_CR,
        F_LF
    } fmt_state_t;
`endif

    typedef enum logic [1:0] {
        T_IDLE,
        T_SEND,
        T_GAP,
        T_WAIT
    } drn_state_t;

    // Storage and state
    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  res_q, res_d;
    fmt_state_t  fmt_q, fmt_d;
    drn_state_t  drn_q, drn_d;

    // Datapath control
    logic        full, empty;
    logic        pop;
    logic        echo_push;
    logic        fmt_req;
    logic        fmt_push;
    logic        push;
    logic [7:0]  push_data;
    logic [7:0]  fmt_char;
    logic        res_drop;
    logic        echo_drop;

    // ASCII hex digit, uppercase
    function automatic logic [7:0] hex_digit(input logic [3:0] n);
        if (n <= 4'd9) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign q_full  = full;
    assign q_empty = empty;
    assign q_ovf   = ovf_q;
    assign tx_data = tx_data_q;
    assign fmt_busy = (fmt_q != F_IDLE);
    // Gated by reset so a strobe never escapes in the reset cycle itself
    assign tx_data_rdy = (drn_q == T_SEND) && !Gl_rst;

    // Write arbitration: echo first, formatter only when echo is absent and room exists
    always_comb begin
        pop       = (drn_q == T_IDLE) && !empty && !bu_tx_busy;
        echo_push = echo_valid && (!full || pop);
        echo_drop = echo_valid && !echo_push;
        fmt_req   = (fmt_q != F_IDLE);
        fmt_push  = fmt_req && !echo_push && !full;
        push      = echo_push || fmt_push;
        res_drop  = res_valid && fmt_req;

        fmt_char = 8'h00;
        case (fmt_q)
`ifdef TXQ_PREFIX_EN
            F_EQ:    fmt_char = 8'h3D;
`endif
            F_HI:    fmt_char = hex_digit(res_q[7:4]);
            F_LO:    fmt_char = hex_digit(res_q[3:0]);
            F_CR:    fmt_char = 8'h0D;
            F_LF:    fmt_char = 8'h0A;
            default: fmt_char = 8'h00;
        endcase

        push_data = echo_push ? echo_data : fmt_char;
    end

    // FIFO pointers, occupancy, output latch and sticky drop flag next-state
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        ovf_d     = ovf_q | res_drop | echo_drop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            tx_data_d = mem_q[rd_ptr_q];
        end
        if (push && !pop) begin
            cnt_d = cnt_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (AW + 1)'(1);
        end
    end

    // Formatter FSM: walk through the characters of one result, advancing only on a granted push
    always_comb begin
        fmt_d = fmt_q;
        res_d = res_q;
        case (fmt_q)
            F_IDLE: begin
                if (res_valid) begin
                    res_d = res_data;
`ifdef TXQ_PREFIX_EN
                    fmt_d = F_EQ;
`else
                    fmt_d = F_HI;
`endif
                end
            end
`ifdef TXQ_PREFIX_EN
            F_EQ:    if (fmt_push) fmt_d = F_HI;
`endif
            F_HI:    if (fmt_push) fmt_d = F_LO;
            F_LO:    if (fmt_push) fmt_d = F_CR;
            F_CR:    if (fmt_push) fmt_d = F_LF;
            F_LF:    if (fmt_push) fmt_d = F_IDLE;
            default: fmt_d = F_IDLE;
        endcase
    end

    // Drain FSM: pop, strobe, one blind gap cycle, then wait for the UART to go idle
    always_comb begin
        drn_d = drn_q;
        case (drn_q)
            T_IDLE:  if (pop) drn_d = T_SEND;
            T_SEND:  drn_d = T_GAP;
            T_GAP:   drn_d = T_WAIT;
            T_WAIT:  if (!bu_tx_busy) drn_d = T_IDLE;
            default: drn_d = T_IDLE;
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (Gl_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            fmt_q     <= F_IDLE;
            drn_q     <= T_IDLE;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            fmt_q     <= fmt_d;
            drn_q     <= drn_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers and count define validity
    always_ff @(posedge clk) begin
        if (push && !Gl_rst) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_tx_fmt_queue.sv
// Self-checking bench for tx_fmt_queue: directed scenarios plus randomized traffic
// against a character-sequence reference model and a simple UART busy model.
module tb_tx_fmt_queue;

    logic       clk = 1'b0;
    logic       Gl_rst = 1'b0;
    logic [7:0] echo_data = 8'h00;
    logic       echo_valid = 1'b0;
    logic [7:0] res_data = 8'h00;
    logic       res_valid = 1'b0;
    logic       bu_tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_data_rdy;
    logic       fmt_busy;
    logic       q_full;
    logic       q_empty;
    logic       q_ovf;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit uart_mode = 0;

    logic [7:0] got[$];
    int         tstamp[$];
    logic [7:0] exp_q[$];

    tx_fmt_queue #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .Gl_rst(Gl_rst),
        .echo_data(echo_data), .echo_valid(echo_valid),
        .res_data(res_data), .res_valid(res_valid),
        .bu_tx_busy(bu_tx_busy),
        .tx_data(tx_data), .tx_data_rdy(tx_data_rdy),
        .fmt_busy(fmt_busy), .q_full(q_full), .q_empty(q_empty), .q_ovf(q_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Output monitor: log every strobed character with its cycle number
    always @(posedge clk) begin
        #1;
        if (tx_data_rdy === 1'b1) begin
            got.push_back(tx_data);
            tstamp.push_back(cyc);
        end
    end

    // UART model: busy rises right after a strobe and stays high a random while
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (uart_mode && tx_data_rdy === 1'b1) begin
                bu_tx_busy = 1'b1;
                repeat ($urandom_range(2, 12)) @(posedge clk);
                #1;
                bu_tx_busy = 1'b0;
            end
        end
    end

    function automatic logic [7:0] hexc(input int n);
        if (n < 10) return 8'(48 + n);
        return 8'(65 + n - 10);
    endfunction

    // Reference: the character string one result turns into
    function automatic void add_res(input logic [7:0] r);
`ifdef TXQ_PREFIX_EN
        exp_q.push_back(8'h3D);
`endif
        exp_q.push_back(hexc(int'(r) / 16));
        exp_q.push_back(hexc(int'(r) % 16));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    task automatic clear_log();
        got.delete();
        tstamp.delete();
        exp_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        Gl_rst = 1'b1;
        @(negedge clk);
        Gl_rst = 1'b0;
    endtask

    task automatic send(input bit ev, input logic [7:0] ed, input bit rv, input logic [7:0] rd);
        @(negedge clk);
        echo_valid = ev;
        echo_data  = ed;
        res_valid  = rv;
        res_data   = rd;
        @(negedge clk);
        echo_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic wait_chars(input int n, input int budget, output bit to);
        int c;
        c = 0;
        to = 0;
        while (got.size() < n) begin
            @(negedge clk);
            c++;
            if (c > budget) begin
                to = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        Gl_rst = 1'b1;
        @(negedge clk);
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%0h exp=0", tx_data); end
        checks++; if (tx_data_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%0b exp=0", tx_data_rdy); end
        checks++; if (fmt_busy !== 1'b0) begin errors++; $display("FAIL reset_fmt_busy got=%0b exp=0", fmt_busy); end
        checks++; if (q_full !== 1'b0) begin errors++; $display("FAIL reset_q_full got=%0b exp=0", q_full); end
        checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL reset_q_empty got=%0b exp=1", q_empty); end
        checks++; if (q_ovf !== 1'b0) begin errors++; $display("FAIL reset_q_ovf got=%0b exp=0", q_ovf); end
        Gl_rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_data_rdy !== 1'b0) begin errors++; $display("FAIL reset_after_rdy got=%0b exp=0", tx_data_rdy); end
    endtask

    task automatic test_format();
        bit to;
        clear_log();
        add_res(8'h3A);
        send(0, 8'h00, 1, 8'h3A);
        checks++; if (fmt_busy !== 1'b1) begin errors++; $display("FAIL fmt_busy_rise got=%0b exp=1", fmt_busy); end
        repeat (3) @(negedge clk);
        checks++; if (fmt_busy !== 1'b1) begin errors++; $display("FAIL fmt_busy_before_lf got=%0b exp=1", fmt_busy); end
        @(negedge clk);
        checks++; if (fmt_busy !== 1'b0) begin errors++; $display("FAIL fmt_busy_after_lf got=%0b exp=0", fmt_busy); end
        wait_chars(exp_q.size(), 200, to);
        checks++; if (to) begin errors++; $display("FAIL format_timeout got=%0d exp=%0d chars", got.size(), exp_q.size()); end
        repeat (20) @(negedge clk);
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL format_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= got.size() || got[k] !== exp_q[k]) begin
                errors++; $display("FAIL format_char[%0d] got=%0h exp=%0h", k, (k < got.size()) ? got[k] : 8'hxx, exp_q[k]);
            end
        end
        for (int k = 1; k < tstamp.size(); k++) begin
            checks++;
            if (tstamp[k] - tstamp[k-1] < 4) begin errors++; $display("FAIL format_spacing[%0d] got=%0d exp>=4", k, tstamp[k] - tstamp[k-1]); end
        end
    endtask

    task automatic test_echo_and_result();
        bit to;
        clear_log();
        exp_q.push_back(8'h35);
        add_res(8'hF0);
        send(1, 8'h35, 1, 8'hF0);
        wait_chars(exp_q.size(), 200, to);
        checks++; if (to) begin errors++; $display("FAIL both_timeout got=%0d exp=%0d chars", got.size(), exp_q.size()); end
        repeat (20) @(negedge clk);
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL both_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= got.size() || got[k] !== exp_q[k]) begin
                errors++; $display("FAIL both_char[%0d] got=%0h exp=%0h", k, (k < got.size()) ? got[k] : 8'hxx, exp_q[k]);
            end
        end
        checks++; if (q_ovf !== 1'b0) begin errors++; $display("FAIL both_ovf got=%0b exp=0", q_ovf); end
    endtask

    task automatic test_overflow();
        bit to;
        apply_reset();
        clear_log();
        @(negedge clk);
        bu_tx_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 8) begin
                checks++; if (q_full !== 1'b1) begin errors++; $display("FAIL ovf_full_at8 got=%0b exp=1", q_full); end
                checks++; if (q_ovf !== 1'b0) begin errors++; $display("FAIL ovf_flag_at8 got=%0b exp=0", q_ovf); end
            end
            echo_valid = 1'b1;
            echo_data  = 8'(8'h30 + i);
            if (i < 8) exp_q.push_back(8'(8'h30 + i));
        end
        @(negedge clk);
        echo_valid = 1'b0;
        checks++; if (q_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag_set got=%0b exp=1", q_ovf); end
        checks++; if (q_full !== 1'b1) begin errors++; $display("FAIL ovf_still_full got=%0b exp=1", q_full); end
        bu_tx_busy = 1'b0;
        wait_chars(8, 300, to);
        checks++; if (to) begin errors++; $display("FAIL ovf_timeout got=%0d exp=8 chars", got.size()); end
        repeat (20) @(negedge clk);
        checks++; if (got.size() != 8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", got.size()); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (k >= got.size() || got[k] !== exp_q[k]) begin
                errors++; $display("FAIL ovf_char[%0d] got=%0h exp=%0h", k, (k < got.size()) ? got[k] : 8'hxx, exp_q[k]);
            end
        end
        checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty_end got=%0b exp=1", q_empty); end
        checks++; if (q_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", q_ovf); end
    endtask

    task automatic test_result_drop();
        bit to;
        apply_reset();
        clear_log();
        add_res(8'h22);
        send(0, 8'h00, 1, 8'h22);
        send(0, 8'h00, 1, 8'h11);
        wait_chars(exp_q.size(), 200, to);
        checks++; if (to) begin errors++; $display("FAIL drop_timeout got=%0d exp=%0d chars", got.size(), exp_q.size()); end
        repeat (40) @(negedge clk);
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL drop_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= got.size() || got[k] !== exp_q[k]) begin
                errors++; $display("FAIL drop_char[%0d] got=%0h exp=%0h", k, (k < got.size()) ? got[k] : 8'hxx, exp_q[k]);
            end
        end
        checks++; if (q_ovf !== 1'b1) begin errors++; $display("FAIL drop_ovf got=%0b exp=1", q_ovf); end
    endtask

    task automatic test_reset_mid_drain();
        bit to;
        int n0;
        apply_reset();
        clear_log();
        @(negedge clk);
        bu_tx_busy = 1'b1;
        send(1, 8'h41, 0, 8'h00);
        send(1, 8'h42, 0, 8'h00);
        send(1, 8'h43, 0, 8'h00);
        checks++; if (q_empty !== 1'b0) begin errors++; $display("FAIL rstmid_filled got=%0b exp=0", q_empty); end
        bu_tx_busy = 1'b0;
        wait_chars(1, 50, to);
        checks++; if (to) begin errors++; $display("FAIL rstmid_timeout got=%0d exp=1 chars", got.size()); end
        @(negedge clk);
        Gl_rst = 1'b1;
        n0 = got.size();
        @(negedge clk);
        checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%0b exp=1", q_empty); end
        checks++; if (fmt_busy !== 1'b0) begin errors++; $display("FAIL rstmid_fmt_busy got=%0b exp=0", fmt_busy); end
        checks++; if (q_ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got=%0b exp=0", q_ovf); end
        checks++; if (tx_data_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_rdy got=%0b exp=0", tx_data_rdy); end
        Gl_rst = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (got.size() != n0) begin errors++; $display("FAIL rstmid_no_strobe got=%0d exp=%0d", got.size(), n0); end
        checks++; if (n0 < 1 || got[0] !== 8'h41) begin errors++; $display("FAIL rstmid_first got=%0h exp=41", (n0 >= 1) ? got[0] : 8'hxx); end
    endtask

    task automatic test_prefix();
        bit to;
        apply_reset();
        clear_log();
        add_res(8'h00);
        send(0, 8'h00, 1, 8'h00);
        wait_chars(exp_q.size(), 200, to);
        checks++; if (to) begin errors++; $display("FAIL prefix_timeout got=%0d exp=%0d chars", got.size(), exp_q.size()); end
        repeat (20) @(negedge clk);
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL prefix_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= got.size() || got[k] !== exp_q[k]) begin
                errors++; $display("FAIL prefix_char[%0d] got=%0h exp=%0h", k, (k < got.size()) ? got[k] : 8'hxx, exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        int c;
        int kind;
        logic [7:0] e;
        logic [7:0] r;
        apply_reset();
        clear_log();
        uart_mode = 1;
        for (int it = 0; it < 24; it++) begin
            c = 0;
            while (!(q_empty === 1'b1 && fmt_busy === 1'b0) && c < 500) begin
                @(negedge clk);
                c++;
            end
            if (c >= 500) begin checks++; errors++; $display("FAIL random_idle_timeout got=%0d exp<500 cycles", c); end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            kind = $urandom_range(0, 3);
            e = 8'($urandom);
            r = 8'($urandom);
            case (kind)
                0: begin exp_q.push_back(e); send(1, e, 0, 8'h00); end
                1: begin add_res(r); send(0, 8'h00, 1, r); end
                2: begin exp_q.push_back(e); add_res(r); send(1, e, 1, r); end
                default: begin
                    for (int j = 0; j < int'($urandom_range(2, 4)); j++) begin
                        @(negedge clk);
                        e = 8'($urandom);
                        echo_valid = 1'b1;
                        echo_data  = e;
                        exp_q.push_back(e);
                    end
                    @(negedge clk);
                    echo_valid = 1'b0;
                end
            endcase
        end
        wait_chars(exp_q.size(), 5000, to);
        checks++; if (to) begin errors++; $display("FAIL random_timeout got=%0d exp=%0d chars", got.size(), exp_q.size()); end
        repeat (40) @(negedge clk);
        uart_mode = 0;
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL random_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= got.size() || got[k] !== exp_q[k]) begin
                errors++; $display("FAIL random_char[%0d] got=%0h exp=%0h", k, (k < got.size()) ? got[k] : 8'hxx, exp_q[k]);
            end
        end
        for (int k = 1; k < tstamp.size(); k++) begin
            checks++;
            if (tstamp[k] - tstamp[k-1] < 4) begin errors++; $display("FAIL random_spacing[%0d] got=%0d exp>=4", k, tstamp[k] - tstamp[k-1]); end
        end
        checks++; if (q_ovf !== 1'b0) begin errors++; $display("FAIL random_ovf got=%0b exp=0", q_ovf); end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_format();
        test_echo_and_result();
        test_overflow();
        test_result_drop();
        test_reset_mid_drain();
        test_prefix();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
